// File: rtl/arb4_rr_ctrl.sv
// Four-requester round-robin arbiter with a one-hot grant and an encoded owner index.
// Latency: 1 clock from request to grant in IDLE; release takes 1 clock; one idle cycle between grants.
// Backpressure: a grant is held while the owner keeps requesting; non-owner requests wait for IDLE.
//
// Optional feature macro: ARB4_RR_TIMEOUT_EN. When defined, a grant is forced off after
// MAX_HOLD GRANT cycles and `timeout` pulses for one cycle. When undefined, grants are held
// indefinitely and `timeout` is tied to 0.
//
// Ports:
//   clk      - single clock, rising edge
//   rst_n    - asynchronous active-low reset
//   req      - level-sensitive requests, bit i is client i
//   gnt      - registered one-hot grant, zero when idle
//   gnt_id   - registered binary owner index, zero when idle
//   gnt_vld  - registered, high while a grant is active (equals |gnt)
//   timeout  - one-cycle pulse when a grant is force-released
module arb4_rr_ctrl #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_vld,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state;
  logic [1:0] last;
  logic [1:0] sel;
  logic [1:0] idx;

  // Elaboration-time guard on the hold limit.
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("arb4_rr_ctrl: MAX_HOLD must be within 1..255");
  end

  // Round-robin pick: scan last+1 .. last+4 (mod 4) and take the first requester.
  // Only consulted when req is non-zero, so the fallback value never matters.
  always_comb begin
    sel = last;
    idx = '0;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (req[idx]) begin
        sel = idx;
      end
    end
  end

`ifdef ARB4_RR_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  // Completed GRANT cycles of the current owner.
  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      last    <= 2'd3;
      gnt     <= '0;
      gnt_id  <= '0;
      gnt_vld <= 1'b0;
      timeout <= 1'b0;
      cnt     <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            gnt     <= 4'b0001 << sel;
            gnt_id  <= sel;
            gnt_vld <= 1'b1;
            last    <= sel;
            cnt     <= '0;
            state   <= GRANT;
          end
        end
        GRANT: begin
          if (!req[gnt_id]) begin
            // Normal release wins over a timeout on the same edge.
            gnt     <= '0;
            gnt_id  <= '0;
            gnt_vld <= 1'b0;
            state   <= IDLE;
          end else if (cnt == HOLD_LAST) begin
            // This edge ends the MAX_HOLD-th GRANT cycle: force release.
            gnt     <= '0;
            gnt_id  <= '0;
            gnt_vld <= 1'b0;
            timeout <= 1'b1;
            state   <= IDLE;
          end else if (cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign timeout = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      last    <= 2'd3;
      gnt     <= '0;
      gnt_id  <= '0;
      gnt_vld <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            gnt     <= 4'b0001 << sel;
            gnt_id  <= sel;
            gnt_vld <= 1'b1;
            last    <= sel;
            state   <= GRANT;
          end
        end
        GRANT: begin
          if (!req[gnt_id]) begin
            gnt     <= '0;
            gnt_id  <= '0;
            gnt_vld <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_arb4_rr_ctrl.sv
// Directed testbench for arb4_rr_ctrl with hand-computed expectations.
// Inputs change 1 ns after a rising edge; outputs are sampled 1 ns after a rising edge.
// All checks go through chk; one summary line at the end.
module tb_arb4_rr_ctrl;

`ifdef ARB4_RR_TIMEOUT_EN
  localparam int MH = 4;
`else
  localparam int MH = 8;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_vld;
  logic       timeout;

  int checks;
  int errors;

  arb4_rr_ctrl #(.MAX_HOLD(MH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] e_gnt, input logic [1:0] e_id,
                         input logic e_vld, input logic e_to);
    chk({tag, ".gnt"},     {4'b0, gnt},     {4'b0, e_gnt});
    chk({tag, ".gnt_id"},  {6'b0, gnt_id},  {6'b0, e_id});
    chk({tag, ".gnt_vld"}, {7'b0, gnt_vld}, {7'b0, e_vld});
    chk({tag, ".timeout"}, {7'b0, timeout}, {7'b0, e_to});
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] oh;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    req    = 4'b0000;

    // Reset state
    #12;
    chk_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // First grant goes to client 0 (last=3 after reset)
    req = 4'b1111;
    step();
    chk_out("first", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Rotation 0 -> 1 -> 2 -> 3 -> 0 with one idle cycle between grants
    for (int i = 0; i < 4; i++) begin
      step();
      oh = 4'b0001 << i;
      chk_out($sformatf("rot%0d_hold", i), oh, 2'(i), 1'b1, 1'b0);
      req = 4'b1111 & ~oh;
      step();
      chk_out($sformatf("rot%0d_idle", i), 4'b0000, 2'd0, 1'b0, 1'b0);
      req = 4'b1111;
      step();
      oh = 4'b0001 << ((i + 1) % 4);
      chk_out($sformatf("rot%0d_next", i), oh, 2'((i + 1) % 4), 1'b1, 1'b0);
    end
    req = 4'b0000;
    step();
    chk_out("rot_release", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Fairness skip: make last=1, then req=1010 alternates 3,1,3
    req = 4'b0010;
    step();
    chk_out("fair_set1", 4'b0010, 2'd1, 1'b1, 1'b0);
    req = 4'b0000;
    step();
    chk_out("fair_idle0", 4'b0000, 2'd0, 1'b0, 1'b0);
    req = 4'b1010;
    step();
    chk_out("fair_g3a", 4'b1000, 2'd3, 1'b1, 1'b0);
    req = 4'b0010;
    step();
    chk_out("fair_idle1", 4'b0000, 2'd0, 1'b0, 1'b0);
    req = 4'b1010;
    step();
    chk_out("fair_g1", 4'b0010, 2'd1, 1'b1, 1'b0);
    req = 4'b1000;
    step();
    chk_out("fair_idle2", 4'b0000, 2'd0, 1'b0, 1'b0);
    req = 4'b1010;
    step();
    chk_out("fair_g3b", 4'b1000, 2'd3, 1'b1, 1'b0);
    req = 4'b0000;
    step();
    chk_out("fair_release", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Non-owner request changes are ignored during GRANT (last=3 -> client 0)
    req = 4'b0001;
    step();
    chk_out("nonown_g0", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b0111;
    step();
    chk_out("nonown_hold1", 4'b0001, 2'd0, 1'b1, 1'b0);
    step();
    chk_out("nonown_hold2", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b0110;
    step();
    chk_out("nonown_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    step();
    chk_out("nonown_g1", 4'b0010, 2'd1, 1'b1, 1'b0);
    req = 4'b0000;
    step();
    chk_out("nonown_release", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Hold test: last=1, req=0001 -> client 0
    req = 4'b0001;
    step();
    chk_out("hold_g0", 4'b0001, 2'd0, 1'b1, 1'b0);
`ifdef ARB4_RR_TIMEOUT_EN
    for (int c = 2; c <= 4; c++) begin
      step();
      chk_out($sformatf("to_cyc%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    step();
    chk_out("to_pulse", 4'b0000, 2'd0, 1'b0, 1'b1);
    step();
    chk_out("to_regrant", 4'b0001, 2'd0, 1'b1, 1'b0);
`else
    for (int c = 2; c <= 110; c++) begin
      step();
      chk($sformatf("hold_gnt%0d", c), {4'b0, gnt}, 8'h01);
      chk($sformatf("hold_to%0d", c), {7'b0, timeout}, 8'h00);
    end
`endif
    req = 4'b0000;
    step();
    chk_out("hold_release", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Mid-grant asynchronous reset (last=0 -> client 1 granted first)
    req = 4'b1111;
    step();
    chk_out("mrst_g1", 4'b0010, 2'd1, 1'b1, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk_out("mrst_async", 4'b0000, 2'd0, 1'b0, 1'b0);
    step();
    chk_out("mrst_held", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    chk_out("mrst_g0", 4'b0001, 2'd0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
